ub_access_scheduler: RTL and testbench
======================================

// Module: ub_access_scheduler
// PURPOSE
//  Shares the Unified Buffer's two read/write ports per bank among NUM_REQ row-wide requesters
//  (host DMA, systolic-array feeder, activation writeback). Up to two requests are granted per
//  cycle, round-robin. Requests use a valid/ready handshake; read data returns with a tag.
//  Sits between the requesters and the Unified Buffer; the scheduler is the sole driver of the
//  buffer's port signals.
// PARAMETERS
//  DATA_WIDTH  8     lane width, equal to the buffer's DATA_WIDTH
//  NUM_BANKS   16    lanes per row access, equal to the buffer's NUM_BANKS
//  BANK_DEPTH  4096  rows per bank; ROW_BITS = $clog2(BANK_DEPTH) (localparam)
//  NUM_REQ     3     number of requesters, >= 2
// PORTS
//  CLK          in   1                       clock
//  ASYNC_RST    in   1                       asynchronous, active-low reset
//  SYNC_RST     in   1                       synchronous reset, active-high, same net as the buffer's
//  EN           in   1                       global advance enable, forwarded as UB_EN
//  REQ_VALID    in   [NUM_REQ]               request valid
//  REQ_READY    out  [NUM_REQ]               grant; handshake = VALID & READY
//  REQ_WRITE    in   [NUM_REQ]               1 = write, 0 = read
//  REQ_ADDR     in   [NUM_REQ][ROW_BITS]     row address
//  REQ_MASK     in   [NUM_REQ][NUM_BANKS]    bank enables
//  REQ_WDATA    in   [NUM_REQ][NUM_BANKS][DW] signed write lanes
//  RSP_VALID    out  [NUM_REQ]               read response valid
//  RSP_DATA     out  [NUM_REQ][NUM_BANKS][DW] read lanes, 0 when RSP_VALID = 0
//  UB_EN        out  1                       = EN
//  UB_P{1,2}_{RD,WR}_VALID/ADDR, UB_P{1,2}_WDATA  out  per bank  buffer port drives, registered
//  UB_P1_RDATA, UB_P2_RDATA  in  [NUM_BANKS][DW]  buffer read data
// BEHAVIOUR
//  - Reset (either kind): REQ_READY = 0, RSP_VALID = 0, RSP_DATA = 0, all UB_* valid = 0,
//    UB_* address and data = 0, rr_ptr = 0, tag pipeline cleared.
//  - Grant (combinational, only when EN = 1): scan requesters from rr_ptr upward, mod NUM_REQ.
//    The first valid requester gets port 1. The next valid requester gets port 2, unless both
//    are writes to the same REQ_ADDR with overlapping REQ_MASK; in that case the second
//    requester waits and no further requester is considered. REQ_READY never depends on a
//    requester's own REQ_READY.
//  - rr_ptr <= (index of last granted requester + 1) mod NUM_REQ. Unchanged if nothing is granted.
//  - Issue: on the handshake edge, the granted port's per-bank RD/WR_VALID are loaded from
//    REQ_MASK (RD or WR selected by REQ_WRITE), along with ADDR and WDATA. Unmasked banks get
//    VALID = 0.
//  - Latency: handshake at cycle N -> UB drives valid in N+1 -> RSP_VALID[id] = 1 in N+2, with
//    RSP_DATA = the granted port's RDATA. Writes produce no response.
//  - Tag pipeline: 2 stages of {valid, id, port}. Two responses to different requesters may
//    occur in the same cycle.
//  - Ordering: a write handshaked at N is visible to a read handshaked at N+1 or later. A read
//    and a write to the same row granted in the same cycle: the read returns the OLD data.
//  - EN = 0: no grants; the tag pipeline and UB_* registers hold; RSP_VALID is held low;
//    responses resume after EN returns. One EN-high cycle equals one latency step.
//  - Reset during in-flight reads: the reads are dropped and no RSP_VALID is ever produced for
//    them. Requesters must reissue.
//  - A requester holding VALID with a fixed request is granted within NUM_REQ cycles while
//    EN = 1 (no starvation).
// STRUCTURE
//  - Package ub_pkg: ROW_BITS helper, req_id_t (clog2 NUM_REQ), ub_port_e {PORT1, PORT2},
//    tag_t {valid, id, port}.
//  - Sub-module ub_rr_picker: combinational 2-grant round-robin picker with the same-row
//    write-conflict rule. Inputs: valid, write, addr, mask, rr_ptr. Outputs: grant1/2 + ids.
//  - Top level: grant registers, UB drive registers, tag pipeline, response mux.
// TESTING
//  1 Preload row 5 = 0x11 in all lanes; REQ0 read addr 5, mask all -> RSP_VALID[0] 2 cycles
//    after handshake, all lanes = 0x11; RSP_VALID[1,2] stay 0.
//  2 REQ0..2 reads held valid, rr_ptr = 0 -> grants {0:P1, 1:P2}, then {2:P1, 0:P2}, then
//    {1:P1, 2:P2}; rr_ptr = 2, 1, 0.
//  3 REQ0 write addr 7 mask 0x0001, REQ1 write addr 7 mask 0x0003 -> only REQ0 granted;
//    REQ1 granted next cycle; final row 7 lanes 0..1 = REQ1 data.
//  4 REQ1 writes 0x5A to addr 9 (cycle N), REQ1 reads addr 9 (N+1) -> RSP_DATA[1] = 0x5A at N+3.
//  5 Read handshaked, then EN = 0 for 3 cycles -> no RSP_VALID while low; response after 2
//    EN-high cycles total, data correct.
//  6 ASYNC_RST low during an in-flight read -> all outputs 0 immediately; after release no
//    RSP_VALID; rr_ptr = 0.

Source files
------------

// File: rtl/ub_pkg.sv
// Shared types for the Unified Buffer access scheduler: requester ids,
// buffer port names and the read-tag record that travels with each access.
package ub_pkg;

  // Default requester count (host DMA, array feeder, activation writeback).
  localparam int UB_NUM_REQ = 3;
  localparam int UB_ID_BITS = (UB_NUM_REQ > 1) ? $clog2(UB_NUM_REQ) : 1;

  // Row address width for a bank of the given depth.
  function automatic int row_bits(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  typedef logic [UB_ID_BITS-1:0] req_id_t;

  typedef enum logic {
    PORT1 = 1'b0,
    PORT2 = 1'b1
  } ub_port_e;

  // One in-flight read: which requester gets the data and from which port.
  typedef struct packed {
    logic     valid;
    req_id_t  id;
    ub_port_e port;
  } tag_t;

endpackage

// File: rtl/ub_rr_picker.sv
// Two-grant round-robin picker. Starting at rr_ptr, the first valid requester
// takes port 1 and the next valid one takes port 2, except that two writes
// hitting the same row with overlapping lanes are never issued together:
// the second one waits and the scan stops there.
module ub_rr_picker
  import ub_pkg::*;
#(
  parameter int NUM_REQ   = UB_NUM_REQ,
  parameter int NUM_BANKS = 16,
  parameter int ROW_BITS  = 12
) (
  input  logic [NUM_REQ-1:0]                valid,
  input  logic [NUM_REQ-1:0]                write,
  input  logic [NUM_REQ-1:0][ROW_BITS-1:0]  addr,
  input  logic [NUM_REQ-1:0][NUM_BANKS-1:0] mask,
  input  req_id_t                           rr_ptr,
  output logic                              grant1,
  output logic                              grant2,
  output req_id_t                           id1,
  output req_id_t                           id2
);

  int      sum;
  req_id_t idx;
  logic    stop;

  // Scan requesters in rotated order and hand out up to two ports
  always_comb begin
    grant1 = 1'b0;
    grant2 = 1'b0;
    id1    = '0;
    id2    = '0;
    stop   = 1'b0;
    sum    = 0;
    idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = int'(rr_ptr) + k;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      idx = req_id_t'(sum);
      if (!stop && valid[idx]) begin
        if (!grant1) begin
          grant1 = 1'b1;
          id1    = idx;
        end else begin
          if (!(write[id1] && write[idx] && (addr[id1] == addr[idx]) &&
                |(mask[id1] & mask[idx]))) begin
            grant2 = 1'b1;
            id2    = idx;
          end
          stop = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ub_access_scheduler.sv
// Shares the Unified Buffer's two ports among NUM_REQ row-wide requesters.
// Grants are combinational; the buffer port drives are registered, and each
// read carries a two-stage tag so its data is steered back to the requester
// two enabled cycles after the handshake.
module ub_access_scheduler
  import ub_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  parameter  int NUM_BANKS  = 16,
  parameter  int BANK_DEPTH = 4096,
  parameter  int NUM_REQ    = UB_NUM_REQ,
  localparam int ROW_BITS   = row_bits(BANK_DEPTH)
) (
  input  logic                                            CLK,
  input  logic                                            ASYNC_RST,
  input  logic                                            SYNC_RST,
  input  logic                                            EN,
  input  logic [NUM_REQ-1:0]                              REQ_VALID,
  output logic [NUM_REQ-1:0]                              REQ_READY,
  input  logic [NUM_REQ-1:0]                              REQ_WRITE,
  input  logic [NUM_REQ-1:0][ROW_BITS-1:0]                REQ_ADDR,
  input  logic [NUM_REQ-1:0][NUM_BANKS-1:0]               REQ_MASK,
  input  logic [NUM_REQ-1:0][NUM_BANKS-1:0][DATA_WIDTH-1:0] REQ_WDATA,
  output logic [NUM_REQ-1:0]                              RSP_VALID,
  output logic [NUM_REQ-1:0][NUM_BANKS-1:0][DATA_WIDTH-1:0] RSP_DATA,
  output logic                                            UB_EN,
  output logic [NUM_BANKS-1:0]                            UB_P1_RD_VALID,
  output logic [NUM_BANKS-1:0][ROW_BITS-1:0]              UB_P1_RD_ADDR,
  output logic [NUM_BANKS-1:0]                            UB_P1_WR_VALID,
  output logic [NUM_BANKS-1:0][ROW_BITS-1:0]              UB_P1_WR_ADDR,
  output logic [NUM_BANKS-1:0][DATA_WIDTH-1:0]            UB_P1_WDATA,
  output logic [NUM_BANKS-1:0]                            UB_P2_RD_VALID,
  output logic [NUM_BANKS-1:0][ROW_BITS-1:0]              UB_P2_RD_ADDR,
  output logic [NUM_BANKS-1:0]                            UB_P2_WR_VALID,
  output logic [NUM_BANKS-1:0][ROW_BITS-1:0]              UB_P2_WR_ADDR,
  output logic [NUM_BANKS-1:0][DATA_WIDTH-1:0]            UB_P2_WDATA,
  input  logic [NUM_BANKS-1:0][DATA_WIDTH-1:0]            UB_P1_RDATA,
  input  logic [NUM_BANKS-1:0][DATA_WIDTH-1:0]            UB_P2_RDATA
);

  req_id_t    rr_ptr_reg, rr_ptr_next;
  logic       pick_g1, pick_g2;
  req_id_t    pick_id1, pick_id2;
  logic       live;
  logic [1:0] port_grant;

  // Nothing is granted or answered while either reset is active or EN is low.
  assign live       = EN & ASYNC_RST & ~SYNC_RST;
  assign port_grant = {pick_g2 & live, pick_g1 & live};
  assign UB_EN      = EN;

  function automatic req_id_t wrap_inc(input req_id_t id);
    return (int'(id) == NUM_REQ - 1) ? '0 : id + req_id_t'(1);
  endfunction

  ub_rr_picker #(
    .NUM_REQ   (NUM_REQ),
    .NUM_BANKS (NUM_BANKS),
    .ROW_BITS  (ROW_BITS)
  ) u_picker (
    .valid  (REQ_VALID),
    .write  (REQ_WRITE),
    .addr   (REQ_ADDR),
    .mask   (REQ_MASK),
    .rr_ptr (rr_ptr_reg),
    .grant1 (pick_g1),
    .grant2 (pick_g2),
    .id1    (pick_id1),
    .id2    (pick_id2)
  );

  // Raise READY for the requesters that own a port this cycle
  always_comb begin
    REQ_READY = '0;
    if (port_grant[0]) REQ_READY[pick_id1] = 1'b1;
    if (port_grant[1]) REQ_READY[pick_id2] = 1'b1;
  end

  // Advance the round-robin pointer past the last requester served
  always_comb begin
    rr_ptr_next = rr_ptr_reg;
    if (port_grant[1])      rr_ptr_next = wrap_inc(pick_id2);
    else if (port_grant[0]) rr_ptr_next = wrap_inc(pick_id1);
  end

  // Round-robin pointer register
  always_ff @(posedge CLK or negedge ASYNC_RST) begin
    if (!ASYNC_RST)    rr_ptr_reg <= '0;
    else if (SYNC_RST) rr_ptr_reg <= '0;
    else               rr_ptr_reg <= rr_ptr_next;
  end

  // One drive register set and tag pipeline per buffer port
  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    logic [NUM_BANKS-1:0]                 rd_valid_reg, wr_valid_reg;
    logic [ROW_BITS-1:0]                  addr_reg;
    logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] wdata_reg;
    tag_t                                 tag_s0_reg, tag_s1_reg;
    req_id_t                              sel_id;

    assign sel_id = (gi == 0) ? pick_id1 : pick_id2;

    // Load the granted request into the port drive; hold everything while EN is low
    always_ff @(posedge CLK or negedge ASYNC_RST) begin
      if (!ASYNC_RST) begin
        rd_valid_reg <= '0;
        wr_valid_reg <= '0;
        addr_reg     <= '0;
        wdata_reg    <= '0;
        tag_s0_reg   <= '0;
        tag_s1_reg   <= '0;
      end else if (SYNC_RST) begin
        rd_valid_reg <= '0;
        wr_valid_reg <= '0;
        addr_reg     <= '0;
        wdata_reg    <= '0;
        tag_s0_reg   <= '0;
        tag_s1_reg   <= '0;
      end else if (EN) begin
        if (port_grant[gi]) begin
          rd_valid_reg <= REQ_WRITE[sel_id] ? '0 : REQ_MASK[sel_id];
          wr_valid_reg <= REQ_WRITE[sel_id] ? REQ_MASK[sel_id] : '0;
          addr_reg     <= REQ_ADDR[sel_id];
          wdata_reg    <= REQ_WDATA[sel_id];
          tag_s0_reg   <= '{valid: !REQ_WRITE[sel_id], id: sel_id,
                            port: (gi == 0) ? PORT1 : PORT2};
        end else begin
          rd_valid_reg <= '0;
          wr_valid_reg <= '0;
          tag_s0_reg   <= '0;
        end
        tag_s1_reg <= tag_s0_reg;
      end
    end
  end

  assign UB_P1_RD_VALID = g_port[0].rd_valid_reg;
  assign UB_P1_WR_VALID = g_port[0].wr_valid_reg;
  assign UB_P1_WDATA    = g_port[0].wdata_reg;
  assign UB_P2_RD_VALID = g_port[1].rd_valid_reg;
  assign UB_P2_WR_VALID = g_port[1].wr_valid_reg;
  assign UB_P2_WDATA    = g_port[1].wdata_reg;

  // Every bank of a port sees the same row
  for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank_addr
    assign UB_P1_RD_ADDR[gi] = g_port[0].addr_reg;
    assign UB_P1_WR_ADDR[gi] = g_port[0].addr_reg;
    assign UB_P2_RD_ADDR[gi] = g_port[1].addr_reg;
    assign UB_P2_WR_ADDR[gi] = g_port[1].addr_reg;
  end

  // Steer returning read data to its requester; two requesters can match at once
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rsp
    logic     hit1, hit2, rsp_v;
    ub_port_e src;

    assign hit1  = g_port[0].tag_s1_reg.valid && (g_port[0].tag_s1_reg.id == req_id_t'(gi));
    assign hit2  = g_port[1].tag_s1_reg.valid && (g_port[1].tag_s1_reg.id == req_id_t'(gi));
    assign src   = hit1 ? g_port[0].tag_s1_reg.port : g_port[1].tag_s1_reg.port;
    assign rsp_v = live & (hit1 | hit2);

    assign RSP_VALID[gi] = rsp_v;
    assign RSP_DATA[gi]  = !rsp_v ? '0 : ((src == PORT1) ? UB_P1_RDATA : UB_P2_RDATA);
  end

endmodule

// File: tb/tb_ub_access_scheduler.sv
// Directed bench for ub_access_scheduler with a behavioural Unified Buffer
// model and a response scoreboard keyed by requester id and arrival cycle.
module tb_ub_access_scheduler;
  import ub_pkg::*;

  localparam int DW    = 8;
  localparam int NB    = 16;
  localparam int DEPTH = 4096;
  localparam int NR    = 3;
  localparam int RB    = 12;

  logic CLK = 1'b0;
  logic ASYNC_RST = 1'b0;
  logic SYNC_RST = 1'b0;
  logic EN = 1'b0;
  logic [NR-1:0]                 REQ_VALID = '0;
  logic [NR-1:0]                 REQ_READY;
  logic [NR-1:0]                 REQ_WRITE = '0;
  logic [NR-1:0][RB-1:0]         REQ_ADDR = '0;
  logic [NR-1:0][NB-1:0]         REQ_MASK = '0;
  logic [NR-1:0][NB-1:0][DW-1:0] REQ_WDATA = '0;
  logic [NR-1:0]                 RSP_VALID;
  logic [NR-1:0][NB-1:0][DW-1:0] RSP_DATA;
  logic                          UB_EN;
  logic [NB-1:0]                 UB_P1_RD_VALID, UB_P1_WR_VALID, UB_P2_RD_VALID, UB_P2_WR_VALID;
  logic [NB-1:0][RB-1:0]         UB_P1_RD_ADDR, UB_P1_WR_ADDR, UB_P2_RD_ADDR, UB_P2_WR_ADDR;
  logic [NB-1:0][DW-1:0]         UB_P1_WDATA, UB_P2_WDATA;
  logic [NB-1:0][DW-1:0]         UB_P1_RDATA, UB_P2_RDATA;

  ub_access_scheduler #(
    .DATA_WIDTH (DW), .NUM_BANKS (NB), .BANK_DEPTH (DEPTH), .NUM_REQ (NR)
  ) dut (
    .CLK (CLK), .ASYNC_RST (ASYNC_RST), .SYNC_RST (SYNC_RST), .EN (EN),
    .REQ_VALID (REQ_VALID), .REQ_READY (REQ_READY), .REQ_WRITE (REQ_WRITE),
    .REQ_ADDR (REQ_ADDR), .REQ_MASK (REQ_MASK), .REQ_WDATA (REQ_WDATA),
    .RSP_VALID (RSP_VALID), .RSP_DATA (RSP_DATA), .UB_EN (UB_EN),
    .UB_P1_RD_VALID (UB_P1_RD_VALID), .UB_P1_RD_ADDR (UB_P1_RD_ADDR),
    .UB_P1_WR_VALID (UB_P1_WR_VALID), .UB_P1_WR_ADDR (UB_P1_WR_ADDR),
    .UB_P1_WDATA (UB_P1_WDATA),
    .UB_P2_RD_VALID (UB_P2_RD_VALID), .UB_P2_RD_ADDR (UB_P2_RD_ADDR),
    .UB_P2_WR_VALID (UB_P2_WR_VALID), .UB_P2_WR_ADDR (UB_P2_WR_ADDR),
    .UB_P2_WDATA (UB_P2_WDATA),
    .UB_P1_RDATA (UB_P1_RDATA), .UB_P2_RDATA (UB_P2_RDATA)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Unified Buffer model: registered read of old data, write after read
  logic [DW-1:0] mem [NB][DEPTH];
  always @(posedge CLK) begin
    if (UB_EN) begin
      for (int b = 0; b < NB; b++) begin
        if (UB_P1_RD_VALID[b]) UB_P1_RDATA[b] <= mem[b][UB_P1_RD_ADDR[b]];
        if (UB_P2_RD_VALID[b]) UB_P2_RDATA[b] <= mem[b][UB_P2_RD_ADDR[b]];
        if (UB_P1_WR_VALID[b]) mem[b][UB_P1_WR_ADDR[b]] <= UB_P1_WDATA[b];
        if (UB_P2_WR_VALID[b]) mem[b][UB_P2_WR_ADDR[b]] <= UB_P2_WDATA[b];
      end
    end
  end

  typedef struct {
    int           id;
    int           at;
    logic [127:0] data;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_rsp(input int id, input int at, input logic [127:0] d);
    exp_t e;
    e.id = id; e.at = at; e.data = d;
    sbq.push_back(e);
  endtask

  // Monitor: match each response to the oldest expectation for that requester
  always @(negedge CLK) begin
    for (int i = 0; i < NR; i++) begin
      if (RSP_VALID[i] === 1'b1) begin
        int k;
        k = -1;
        for (int j = 0; j < sbq.size(); j++) begin
          if (k < 0 && sbq[j].id == i) k = j;
        end
        $display("rsp cyc=%0d id=%0d data=%0h", cyc, i, RSP_DATA[i]);
        if (k < 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_rsp: id %0d responded at cycle %0d, expected none", i, cyc);
        end else begin
          check($sformatf("rsp_cycle_id%0d", i), 128'(cyc), 128'(sbq[k].at));
          check($sformatf("rsp_data_id%0d", i), RSP_DATA[i], sbq[k].data);
          sbq.delete(k);
        end
      end
    end
    for (int j = sbq.size() - 1; j >= 0; j--) begin
      if (sbq[j].at < cyc) begin
        n_checks++;
        n_fail++;
        $display("FAIL missing_rsp: id %0d got nothing by cycle %0d, required at %0d",
                 sbq[j].id, cyc, sbq[j].at);
        sbq.delete(j);
      end
    end
  end

  task automatic drive(input int i, input logic wr, input int addr,
                       input logic [NB-1:0] mask, input logic [7:0] lane);
    REQ_VALID[i] = 1'b1;
    REQ_WRITE[i] = wr;
    REQ_ADDR[i]  = RB'(addr);
    REQ_MASK[i]  = mask;
    REQ_WDATA[i] = {NB{lane}};
    $display("req cyc=%0d id=%0d wr=%0b addr=%0d mask=%0h lane=%0h", cyc, i, wr, addr, mask, lane);
  endtask

  task automatic sync_reset();
    @(negedge CLK);
    REQ_VALID = '0;
    SYNC_RST  = 1'b1;
    @(negedge CLK);
    SYNC_RST = 1'b0;
    #1;
    check("sync_rst_rr_ptr", 128'(dut.rr_ptr_reg), 128'd0);
  endtask

  initial begin
    // Reset state, with all requesters asking
    REQ_VALID = '1;
    repeat (2) @(negedge CLK);
    EN = 1'b1;
    #1;
    check("rst_ready", 128'(REQ_READY), 128'd0);
    check("rst_rsp_valid", 128'(RSP_VALID), 128'd0);
    check("rst_rsp_data0", RSP_DATA[0], 128'd0);
    check("rst_p1_rd_valid", 128'(UB_P1_RD_VALID), 128'd0);
    check("rst_p2_wr_valid", 128'(UB_P2_WR_VALID), 128'd0);
    check("rst_rr_ptr", 128'(dut.rr_ptr_reg), 128'd0);
    REQ_VALID = '0;
    ASYNC_RST = 1'b1;

    // Preload row 5 with 0x11
    @(negedge CLK);
    drive(0, 1'b1, 5, '1, 8'h11);
    #1 check("preload_ready", 128'(REQ_READY), 128'b001);
    @(negedge CLK);
    REQ_VALID = '0;
    sync_reset();

    // 1: single read of row 5
    @(negedge CLK);
    drive(0, 1'b0, 5, '1, 8'h00);
    #1 check("t1_ready", 128'(REQ_READY), 128'b001);
    expect_rsp(0, cyc + 2, {NB{8'h11}});
    @(negedge CLK);
    REQ_VALID = '0;
    repeat (3) @(negedge CLK);
    sync_reset();

    // 2: three readers held valid, rotation of two grants per cycle
    @(negedge CLK);
    drive(0, 1'b0, 5, '1, 8'h00);
    drive(1, 1'b0, 5, '1, 8'h00);
    drive(2, 1'b0, 5, '1, 8'h00);
    #1;
    check("t2_ptr0", 128'(dut.rr_ptr_reg), 128'd0);
    check("t2_ready0", 128'(REQ_READY), 128'b011);
    expect_rsp(0, cyc + 2, {NB{8'h11}});
    expect_rsp(1, cyc + 2, {NB{8'h11}});
    @(negedge CLK);
    #1;
    check("t2_ptr1", 128'(dut.rr_ptr_reg), 128'd2);
    check("t2_ready1", 128'(REQ_READY), 128'b101);
    expect_rsp(2, cyc + 2, {NB{8'h11}});
    expect_rsp(0, cyc + 2, {NB{8'h11}});
    @(negedge CLK);
    #1;
    check("t2_ptr2", 128'(dut.rr_ptr_reg), 128'd1);
    check("t2_ready2", 128'(REQ_READY), 128'b110);
    expect_rsp(1, cyc + 2, {NB{8'h11}});
    expect_rsp(2, cyc + 2, {NB{8'h11}});
    @(negedge CLK);
    REQ_VALID = '0;
    #1 check("t2_ptr3", 128'(dut.rr_ptr_reg), 128'd0);
    repeat (3) @(negedge CLK);
    sync_reset();

    // 3: overlapping same-row writes are serialised; later write wins
    @(negedge CLK);
    drive(2, 1'b1, 7, '1, 8'h00);
    #1 check("t3_clear_ready", 128'(REQ_READY), 128'b100);
    @(negedge CLK);
    REQ_VALID = '0;
    drive(0, 1'b1, 7, 16'h0001, 8'hA0);
    drive(1, 1'b1, 7, 16'h0003, 8'hB1);
    #1 check("t3_conflict_ready", 128'(REQ_READY), 128'b001);
    @(negedge CLK);
    REQ_VALID[0] = 1'b0;
    #1 check("t3_second_ready", 128'(REQ_READY), 128'b010);
    @(negedge CLK);
    REQ_VALID = '0;
    drive(2, 1'b0, 7, '1, 8'h00);
    #1 check("t3_read_ready", 128'(REQ_READY), 128'b100);
    expect_rsp(2, cyc + 2, 128'h0000_0000_0000_0000_0000_0000_0000_B1B1);
    @(negedge CLK);
    REQ_VALID = '0;
    repeat (3) @(negedge CLK);

    // 4: write then read of row 9 on consecutive cycles
    @(negedge CLK);
    drive(1, 1'b1, 9, '1, 8'h5A);
    #1 check("t4_wr_ready", 128'(REQ_READY), 128'b010);
    @(negedge CLK);
    drive(1, 1'b0, 9, '1, 8'h00);
    #1 check("t4_rd_ready", 128'(REQ_READY), 128'b010);
    expect_rsp(1, cyc + 2, {NB{8'h5A}});
    @(negedge CLK);
    REQ_VALID = '0;
    repeat (3) @(negedge CLK);

    // 5: EN low for three cycles stalls the read
    @(negedge CLK);
    drive(0, 1'b0, 5, '1, 8'h00);
    #1 check("t5_ready", 128'(REQ_READY), 128'b001);
    expect_rsp(0, cyc + 5, {NB{8'h11}});
    @(negedge CLK);
    REQ_VALID = '0;
    EN = 1'b0;
    drive(1, 1'b0, 9, '1, 8'h00);
    #1 check("t5_en_low_ready", 128'(REQ_READY), 128'b000);
    repeat (2) @(negedge CLK);
    #1 check("t5_hold_p1_rd_valid", 128'(UB_P1_RD_VALID), 128'hFFFF);
    @(negedge CLK);
    REQ_VALID = '0;
    EN = 1'b1;
    repeat (4) @(negedge CLK);

    // 6: asynchronous reset drops an in-flight read
    @(negedge CLK);
    drive(0, 1'b0, 5, '1, 8'h00);
    #1 check("t6_ready", 128'(REQ_READY), 128'b001);
    @(negedge CLK);
    REQ_VALID = '0;
    #1;
    check("t6_pre_p1_rd_valid", 128'(UB_P1_RD_VALID), 128'hFFFF);
    check("t6_pre_rr_ptr", 128'(dut.rr_ptr_reg), 128'd1);
    REQ_VALID = '1;
    #1 ASYNC_RST = 1'b0;
    #1;
    check("t6_rst_ready", 128'(REQ_READY), 128'd0);
    check("t6_rst_rsp_valid", 128'(RSP_VALID), 128'd0);
    check("t6_rst_p1_rd_valid", 128'(UB_P1_RD_VALID), 128'd0);
    check("t6_rst_p1_rd_addr", 128'(UB_P1_RD_ADDR[0]), 128'd0);
    check("t6_rst_rr_ptr", 128'(dut.rr_ptr_reg), 128'd0);
    @(negedge CLK);
    REQ_VALID = '0;
    @(negedge CLK);
    ASYNC_RST = 1'b1;
    repeat (5) @(negedge CLK);
    #1;
    check("t6_post_rr_ptr", 128'(dut.rr_ptr_reg), 128'd0);
    check("scoreboard_empty", 128'(sbq.size()), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit so the run always ends
  initial begin
    #100000;
    $display("FAIL timeout: simulation still running at %0t, limit 100000", $time);
    $fatal(1, "timeout");
  end

endmodule
